clk_div_monitor: RTL and testbench

- Checks one divided clock produced by the frequency-divider stage (2x/3x/4x/5x outputs) against an expected divide ratio.
- Samples the divided clock in the clk_in domain and measures its period and high time in clk_in cycles.
- Reports lock after consecutive good periods and counts errors.
- Sits directly downstream of the divider; feeds status to the test controller / scan-visible registers.

---
 rtl/clk_div_mon_pkg.sv | 13 +
 rtl/clk_div_monitor_sync.sv | 34 +++
 rtl/clk_div_monitor.sv | 129 ++++++++++++
 tb/tb_clk_div_monitor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/clk_div_mon_pkg.sv
// clk_div_mon_pkg: shared state type, widths and period-match helper for the divided-clock monitor.
package clk_div_mon_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_e;

    localparam int ERR_CNT_W = 8;

    // Odd ratios may land their falling edge on negedge, so either half of N is a valid high time.
    function automatic logic period_match(input logic [31:0] p, input logic [31:0] h, input logic [31:0] n);
        return (p == n) && ((h == (n >> 1)) || (h == ((n + 32'd1) >> 1)));
    endfunction

endpackage

// File: rtl/clk_div_monitor_sync.sv
// sync_edge_det: multi-flop synchroniser with rise/fall pulses from the synchronised level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        dly_d  = sync;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sync = sync_q[STAGES-1];
    assign rise = sync & ~dly_q;
    assign fall = ~sync & dly_q;

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of a divided clock in clk_in cycles, reports lock and errors.
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CNT_W-1:0]     div_sel,
    input  logic                 div_in,
    output logic                 meas_valid,
    output logic [CNT_W-1:0]     period,
    output logic [CNT_W-1:0]     high_time,
    output logic                 lock,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam logic [CNT_W-1:0] ALL1   = '1;
    localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);

    logic sync, rise, fall_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (div_in),
        .sync   (sync),
        .rise   (rise),
        .fall   (fall_unused)
    );

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     per_q, per_d, hi_q, hi_d, period_q, period_d, high_q, high_d, sel_q, sel_d;
    logic                 meas_q, meas_d, err_q, err_d, lock_q, lock_d;
    logic [3:0]           good_q, good_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 match;

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        period_d  = period_q;
        high_d    = high_q;
        meas_d    = 1'b0;
        err_d     = 1'b0;
        lock_d    = lock_q;
        good_d    = good_q;
        err_cnt_d = err_cnt_q;
        sel_d     = div_sel;
        match     = period_match(32'(per_q), 32'(hi_q), 32'(div_sel));
        if (!en) begin
            state_d = IDLE;
            lock_d  = 1'b0;
            good_d  = '0;
        end else if (div_sel != sel_q) begin
            // A new ratio invalidates any measurement in flight, including a coincident rise.
            state_d = WAIT_EDGE;
            lock_d  = 1'b0;
            good_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = WAIT_EDGE;
        end else if (state_q == WAIT_EDGE) begin
            if (rise) begin
                state_d = MEASURE;
                per_d   = CNT_W'(1);
                hi_d    = CNT_W'(1);
            end
        end else if (rise || per_q == ALL1) begin
            meas_d   = 1'b1;
            period_d = per_q;
            high_d   = hi_q;
            per_d    = CNT_W'(1);
            hi_d     = CNT_W'(1);
            if (rise && match) begin
                good_d = (good_q == LOCK_N) ? good_q : good_q + 4'd1;
                lock_d = (good_d == LOCK_N);
            end else begin
                err_d     = 1'b1;
                lock_d    = 1'b0;
                good_d    = '0;
                err_cnt_d = err_cnt_q + ERR_CNT_W'(~&err_cnt_q);
                state_d   = rise ? MEASURE : WAIT_EDGE;
            end
        end else begin
            per_d = per_q + CNT_W'(1);
            hi_d  = hi_q + CNT_W'(sync);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            per_q     <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            sel_q     <= '0;
            meas_q    <= 1'b0;
            err_q     <= 1'b0;
            lock_q    <= 1'b0;
            good_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            hi_q      <= hi_d;
            period_q  <= period_d;
            high_q    <= high_d;
            sel_q     <= sel_d;
            meas_q    <= meas_d;
            err_q     <= err_d;
            lock_q    <= lock_d;
            good_q    <= good_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign meas_valid = meas_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign lock       = lock_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed checks of measurement, lock, error, timeout, ratio change and reset.
module tb_clk_div_monitor;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       en     = 1'b0;
    logic [7:0] div_sel = '0;
    logic       div_in = 1'b0;
    logic       meas_valid, lock, err;
    logic [7:0] period, high_time, err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;
    int hc    = 0;
    int cyc   = 0;
    int rises = 0;

    clk_div_monitor dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .div_sel    (div_sel),
        .div_in     (div_in),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .lock       (lock),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    always @(posedge div_in) rises <= rises + 1;

    // Divide-by-mode generator stepping on both clk_in edges; 50% duty in half-cycles.
    initial forever begin
        @(clk_in);
        #1;
        if (mode == 0) begin
            hc     = 0;
            div_in = 1'b0;
        end else begin
            div_in = (hc < mode);
            hc     = (hc + 1 >= 2 * mode) ? 0 : hc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_meas(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!meas_valid && n < budget);
        check(tag, 32'(meas_valid), 1);
    endtask

    task automatic switch_sel(input int n);
        mode = 0;
        repeat (4) @(negedge clk_in);
        div_sel = 8'(n);
        @(negedge clk_in);
        check("sel_lock_drop", 32'(lock), 0);
        check("sel_no_err", 32'(err), 0);
        mode = n;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_meas"}, 32'(meas_valid), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_high"}, 32'(high_time), 0);
        check({tag, "_lock"}, 32'(lock), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_errcnt"}, 32'(err_cnt), 0);
    endtask

    initial begin
        int last, r0;
        repeat (3) @(negedge clk_in);
        check_zero("rst");

        rst_n   = 1'b1;
        en      = 1'b1;
        div_sel = 8'd2;
        mode    = 2;
        for (int i = 0; i < 4; i++) begin
            next_meas("t1_meas", 20);
            check("t1_period", 32'(period), 2);
            check("t1_high", 32'(high_time), 1);
            check("t1_err", 32'(err), 0);
            check("t1_lock", 32'(lock), 32'(i == 3));
            if (i > 0) check("t1_spacing", 32'(cyc - last), 2);
            last = cyc;
        end
        check("t1_errcnt", 32'(err_cnt), 0);

        switch_sel(3);
        for (int i = 0; i < 4; i++) begin
            next_meas("t2_meas", 20);
            check("t2_period", 32'(period), 3);
            check("t2_high_ok", 32'(high_time == 8'd1 || high_time == 8'd2), 1);
            check("t2_err", 32'(err), 0);
            check("t2_lock", 32'(lock), 32'(i == 3));
        end

        switch_sel(4);
        mode = 5;
        for (int i = 0; i < 3; i++) begin
            next_meas("t3_meas", 20);
            check("t3_period", 32'(period), 5);
            check("t3_err", 32'(err), 1);
            check("t3_lock", 32'(lock), 0);
        end
        check("t3_errcnt", 32'(err_cnt), 3);

        switch_sel(5);
        for (int i = 0; i < 4; i++) begin
            next_meas("t4_lock_meas", 30);
            check("t4_lock", 32'(lock), 32'(i == 3));
        end
        mode = 0;
        next_meas("t4_timeout_meas", 300);
        check("t4_to_err", 32'(err), 1);
        check("t4_to_period", 32'(period), 255);
        check("t4_to_lock", 32'(lock), 0);
        check("t4_errcnt", 32'(err_cnt), 4);
        mode = 5;
        for (int i = 0; i < 4; i++) begin
            next_meas("t4_relock_meas", 30);
            check("t4_relock_period", 32'(period), 5);
            check("t4_relock_high_ok", 32'(high_time == 8'd2 || high_time == 8'd3), 1);
            check("t4_relock_err", 32'(err), 0);
            check("t4_relock", 32'(lock), 32'(i == 3));
        end

        switch_sel(2);
        for (int i = 0; i < 4; i++) next_meas("t5_pre_meas", 20);
        check("t5_locked", 32'(lock), 1);
        switch_sel(4);
        for (int i = 0; i < 4; i++) begin
            next_meas("t5_meas", 30);
            check("t5_period", 32'(period), 4);
            check("t5_high", 32'(high_time), 2);
            check("t5_err", 32'(err), 0);
            check("t5_lock", 32'(lock), 32'(i == 3));
        end
        check("t5_errcnt", 32'(err_cnt), 4);

        @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1 check_zero("t6_async");
        en   = 1'b0;
        mode = 0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        en = 1'b1;
        repeat (3) @(negedge clk_in);
        r0   = rises;
        mode = 4;
        next_meas("t6_meas", 40);
        check("t6_rises", 32'(rises - r0), 2);
        check("t6_period", 32'(period), 4);
        check("t6_high", 32'(high_time), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
